// File: rtl/ft600_pkg.sv
// Shared types and bus widths for the FT600 245-mode receive path.
package ft600_pkg;
  localparam int FT_DATA_W = 16;
  localparam int FT_BE_W   = 2;
  localparam int FT_WORD_W = FT_DATA_W + FT_BE_W;

  typedef enum logic [1:0] {IDLE, OE, READ, RELEASE} ft_rd_state_t;
endpackage

// File: rtl/ft600_rx_fifo.sv
// Single-clock first-word-fall-through FIFO: head word is visible on dout the cycle after its push, zero while empty.
// A pop while empty is ignored; the writer must never push while full.
module ft600_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign empty = (r_count == '0);
  assign w_pop = pop & ~empty;
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!push && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && r_count == CNT_FULL));
endmodule

// File: rtl/ft600_read.sv
// FT600 245-sync-FIFO read engine: drives OE#/RD#, registers the pad inputs and buffers words in a skid FIFO.
// Pad word reaches dout two edges after its READ edge; bursts stop while fewer than SKID_MARGIN entries are free.
module ft600_read
  import ft600_pkg::*;
#(
  parameter int SKID_DEPTH  = 16,
  parameter int SKID_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 ft_rxf_n,
  input  logic [FT_DATA_W-1:0] ft_data,
  input  logic [FT_BE_W-1:0]   ft_be,
  output logic                 ft_oe_n,
  output logic                 ft_rd_n,
  output logic                 busy,
  output logic [FT_DATA_W-1:0] dout,
  output logic [FT_BE_W-1:0]   dout_be,
  output logic                 dout_valid,
  input  logic                 dout_ready
);
  localparam int CW = $clog2(SKID_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(SKID_DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(SKID_MARGIN);

  ft_rd_state_t          r_state;
  logic                  r_oe_n;
  logic                  r_rd_n;
  logic                  r_busy;
  logic                  r_rxf_n_q;
  logic [FT_DATA_W-1:0]  r_data_q;
  logic [FT_BE_W-1:0]    r_be_q;
  logic                  r_rd_act_q;

  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_free;
  logic                  w_room;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic [FT_WORD_W-1:0]  w_fifo_dout;

  // The margin covers the word still in the input registers when READ is left.
  assign w_free = DEPTH_C - w_count;
  assign w_room = (w_free >= MARGIN_C);
  assign w_push = r_rd_act_q & ~r_rxf_n_q;
  assign w_pop  = dout_valid & dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxf_n_q  <= 1'b1;
      r_data_q   <= '0;
      r_be_q     <= '0;
      r_rd_act_q <= 1'b0;
    end else begin
      r_rxf_n_q  <= ft_rxf_n;
      r_data_q   <= ft_data;
      r_be_q     <= ft_be;
      r_rd_act_q <= (r_state == READ);
    end
  end

  // Strobes and busy are registered from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_oe_n  <= 1'b1;
      r_rd_n  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && !ft_rxf_n && w_room) begin
            r_state <= OE;
            r_oe_n  <= 1'b0;
            r_rd_n  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        OE: begin
          r_state <= READ;
          r_oe_n  <= 1'b0;
          r_rd_n  <= 1'b0;
          r_busy  <= 1'b1;
        end
        READ: begin
          if (ft_rxf_n || !w_room || !enable) begin
            r_state <= RELEASE;
            r_oe_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        RELEASE: begin
          r_state <= IDLE;
          r_oe_n  <= 1'b1;
          r_rd_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_oe_n  <= 1'b1;
          r_rd_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  ft600_rx_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (FT_WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({r_be_q, r_data_q}),
    .dout  (w_fifo_dout),
    .empty (w_empty),
    .count (w_count)
  );

  assign ft_oe_n    = r_oe_n;
  assign ft_rd_n    = r_rd_n;
  assign busy       = r_busy;
  assign dout_valid = ~w_empty;
  assign dout       = w_fifo_dout[FT_DATA_W-1:0];
  assign dout_be    = w_fifo_dout[FT_WORD_W-1:FT_DATA_W];
endmodule

// File: doc/ft600_read.md
# ft600_read

Host-to-FPGA receive path for the FT600 in 245 synchronous FIFO mode, complementing the existing transmit path. The block runs entirely in the FT600 clock domain and drives the FT600 read strobes (`ft_oe_n`, `ft_rd_n`). It captures 16-bit words plus byte enables into an internal first-word-fall-through skid FIFO and presents them downstream on a valid/ready stream. A top-level arbiter uses `busy` to decide bus ownership between read and write.

## Interface
- `SKID_DEPTH`, 16: skid FIFO depth in words; power of two, ≥ 8.
- `SKID_MARGIN`, 4: minimum free entries required to start or continue a read burst.
- `clk` in 1: FT600 clock (`ft_clk` at top level); sole clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: arbiter grant; while low the FSM does not leave IDLE.
- `ft_rxf_n` in 1: FT600 receive-FIFO-not-empty, active low.
- `ft_data` in 16: FT600 data bus, input half of the pad.
- `ft_be` in 2: FT600 byte enables, input half of the pad.
- `ft_oe_n` out 1: FT600 output enable, active low.
- `ft_rd_n` out 1: FT600 read strobe, active low.
- `busy` out 1: high in any state other than IDLE. The FPGA must tri-state `ft_data`/`ft_be` while `busy` is high.
- `dout` out 16: received word.
- `dout_be` out 2: byte enables of `dout`.
- `dout_valid` out 1: skid FIFO not empty.
- `dout_ready` in 1: downstream accepts; a pop occurs on `dout_valid & dout_ready`.

## Operation
- Input stage: `ft_rxf_n`, `ft_data`, and `ft_be` are registered once (IOB flops) into `rxf_n_q`, `data_q`, and `be_q`. `rd_act_q` is `state==READ` delayed by one cycle.
- Push into the skid FIFO when `rd_act_q & ~rxf_n_q`. The pushed payload is `{be_q, data_q}`.
- `free` = `SKID_DEPTH - count`. `count` is `$clog2(SKID_DEPTH)+1` bits wide and updates on push, pop, or both; simultaneous push and pop leaves `count` unchanged.
- FSM states:
  - IDLE: `oe_n=1`, `rd_n=1`. Go to OE when `enable & ~ft_rxf_n & free ≥ SKID_MARGIN`.
  - OE: `oe_n=0`, `rd_n=1`. Bus turnaround, exactly 1 cycle, then READ.
  - READ: `oe_n=0`, `rd_n=0`. Go to RELEASE when `ft_rxf_n==1` (raw), or `free < SKID_MARGIN`, or `enable==0`.
  - RELEASE: `oe_n=1`, `rd_n=1`. Exactly 1 cycle, then IDLE.
- The margin absorbs the one in-flight word that arrives after leaving READ, so a push never occurs while full. Push-when-full is a design error and is checked by an assertion.
- Words are never dropped or reordered, and `dout_be` is passed through unmodified. A word with `be=2'b00` is still pushed.
- `enable` falling mid-burst ends the burst through RELEASE. Words already registered are still pushed.

## Timing
- Reset values:
  - Control: state IDLE, `ft_oe_n=1`, `ft_rd_n=1`, `busy=0`.
  - Datapath: `dout_valid=0`, `dout=0`, `dout_be=0`, `count=0`, and all `_q` registers cleared with `rxf_n_q=1`.
- Reset mid-burst: the next cycle shows the reset values above. Buffered data is discarded.
- Burst overhead: IDLE→OE→READ takes 2 cycles from `ft_rxf_n` falling to `ft_rd_n` low.
- Data latency:
  - A word present on `ft_data` at a READ edge with `ft_rxf_n=0` is pushed at the next edge.
  - It appears on `dout` with `dout_valid=1` one cycle after that (FWFT).
- Throughput: 1 word/cycle while READ, with the FIFO draining at rate.
- `busy` is registered, derived from the next state, and is asserted from the first OE cycle through the RELEASE cycle inclusive.

## Structure
- Package `ft600_pkg`: `typedef enum logic [1:0] {IDLE, OE, READ, RELEASE} ft_rd_state_t;` plus the bus width constants `FT_DATA_W=16` and `FT_BE_W=2`.
- Sub-module `ft600_rx_fifo`: single-clock FWFT FIFO with parameter `DEPTH` and width 18. Ports: push, pop, din, dout, empty, count. Synchronous reset.
- `ft600_read` contains the FSM, input registers, and free-space logic.

## Test plan
- Single word: `ft_rxf_n` low for exactly one READ cycle carrying `0xA55A`, be `2'b11`. Expected: `ft_oe_n` low 2 cycles then RELEASE, one pop of `0xA55A`/`2'b11`, then IDLE.
- Burst of 64 words `0x0000`–`0x003F` with `dout_ready=1`. Expected: a single burst, 64 words in order, no gaps on `dout_valid` after the first.
- Back-pressure: `dout_ready=0` with 100 words pending. Expected: READ exits when `free<4`, `count` peaks ≤ 16 with no overflow. Raising `dout_ready` restarts bursts, and all 100 words are delivered in order.
- `enable` dropped mid-burst after word 10. Expected: RELEASE follows, words 0–10 (plus at most 1 in-flight) are delivered, and no READ occurs until `enable=1`.
- `rst` asserted during READ with 5 words buffered. Expected: next cycle `ft_oe_n=1`, `ft_rd_n=1`, `busy=0`, `dout_valid=0`.
- Odd-byte tail: last word `0x00EF`, be `2'b01`. Expected: `dout_be=2'b01` delivered unchanged.
